// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM encoding,
// CSR addresses, cause codes and the CSR bit positions the sequencer touches.
package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_MEPC   = 3'd1,
    ST_W_MCAUSE = 3'd2,
    ST_W_MTVAL  = 3'd3,
    ST_W_MSTAT  = 3'd4,
    ST_REDIR    = 3'd5
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Cause codes are the low bits; the interrupt flag sits in the MSB of mcause.
  localparam logic [4:0] CAUSE_IRQ_EXT   = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_SW    = 5'd3;
  localparam logic [4:0] CAUSE_IRQ_TIMER = 5'd7;
  localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
  localparam logic [4:0] CAUSE_ECALL_M   = 5'd11;
  localparam logic [4:0] CAUSE_BREAK     = 5'd3;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP0 = 11;
  localparam int MSTATUS_MPP1 = 12;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

endpackage

// File: rtl/trap_ctrl_prio.sv
// Combinational priority encoder: picks the winning trap source for the EXE
// instruction and produces cause/tval for it.
module trap_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            exe_valid_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic [XLEN-1:0] exe_inst_i,
  input  logic            exc_illegal_i,
  input  logic            exc_ecall_i,
  input  logic            exc_ebreak_i,
  input  logic            exc_mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  output logic            take_o,
  output logic            is_irq_o,
  output logic            is_mret_o,
  output logic [XLEN-1:0] cause_o,
  output logic [XLEN-1:0] tval_o
);

  logic       ext_p;
  logic       sw_p;
  logic       tmr_p;
  logic [4:0] code;
  logic       unused_mie;

  // Only MEIE/MSIE/MTIE matter here; the remaining mie bits are ignored.
  assign unused_mie = ^mie_i;

  assign ext_p = mstatus_mie_i & irq_ext_i   & mie_i[MIE_MEIE];
  assign sw_p  = mstatus_mie_i & irq_sw_i    & mie_i[MIE_MSIE];
  assign tmr_p = mstatus_mie_i & irq_timer_i & mie_i[MIE_MTIE];

  always_comb begin
    take_o    = 1'b0;
    is_irq_o  = 1'b0;
    is_mret_o = 1'b0;
    code      = '0;
    tval_o    = '0;
    if (ext_p) begin
      take_o   = 1'b1;
      is_irq_o = 1'b1;
      code     = CAUSE_IRQ_EXT;
    end else if (sw_p) begin
      take_o   = 1'b1;
      is_irq_o = 1'b1;
      code     = CAUSE_IRQ_SW;
    end else if (tmr_p) begin
      take_o   = 1'b1;
      is_irq_o = 1'b1;
      code     = CAUSE_IRQ_TIMER;
    end else if (exe_valid_i) begin
      if (exc_illegal_i) begin
        take_o = 1'b1;
        code   = CAUSE_ILLEGAL;
        tval_o = exe_inst_i;
      end else if (exc_ecall_i) begin
        take_o = 1'b1;
        code   = CAUSE_ECALL_M;
      end else if (exc_ebreak_i) begin
        take_o = 1'b1;
        code   = CAUSE_BREAK;
        tval_o = exe_pc_i;
      end else if (exc_mret_i) begin
        take_o    = 1'b1;
        is_mret_o = 1'b1;
      end
    end
    cause_o           = XLEN'(code);
    cause_o[XLEN-1]   = is_irq_o;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: accepts one trap in IDLE, writes the trap
// CSRs one per cycle through a single write port, then redirects fetch.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exe_valid,
  input  logic [XLEN-1:0] exe_pc,
  input  logic [XLEN-1:0] exe_inst,
  input  logic            exc_illegal,
  input  logic            exc_ecall,
  input  logic            exc_ebreak,
  input  logic            exc_mret,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            pipe_flush,
  output logic            pipe_stall,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            trap_busy,
  output logic [2:0]      dbg_state_o
);

  // Redirect handshake: redir_valid rises in REDIR and, together with
  // redir_pc, holds stable until a cycle with redir_ready=1; the transfer
  // completes on that clock edge and the FSM is back in IDLE afterwards.

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] mstat_q, mstat_d;

  logic            take_w;
  logic            is_irq_w;
  logic            is_mret_w;
  logic [XLEN-1:0] cause_w;
  logic [XLEN-1:0] tval_w;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] new_mstatus;

  trap_prio_enc #(.XLEN(XLEN)) u_prio (
    .exe_valid_i   (exe_valid),
    .exe_pc_i      (exe_pc),
    .exe_inst_i    (exe_inst),
    .exc_illegal_i (exc_illegal),
    .exc_ecall_i   (exc_ecall),
    .exc_ebreak_i  (exc_ebreak),
    .exc_mret_i    (exc_mret),
    .irq_ext_i     (irq_ext),
    .irq_sw_i      (irq_sw),
    .irq_timer_i   (irq_timer),
    .mstatus_mie_i (csr_mstatus[MSTATUS_MIE]),
    .mie_i         (csr_mie),
    .take_o        (take_w),
    .is_irq_o      (is_irq_w),
    .is_mret_o     (is_mret_w),
    .cause_o       (cause_w),
    .tval_o        (tval_w)
  );

  // Vectored mode only applies to interrupts; exceptions always use the base.
  assign trap_base   = csr_mtvec & ~XLEN'(3);
  assign trap_target = (csr_mtvec[1:0] == 2'b01 && is_irq_w)
                     ? trap_base + (XLEN'(cause_w[4:0]) << 2)
                     : trap_base;

  always_comb begin
    new_mstatus                              = csr_mstatus;
    new_mstatus[MSTATUS_MPP1:MSTATUS_MPP0]   = 2'b11;
    if (is_mret_w) begin
      new_mstatus[MSTATUS_MIE]  = csr_mstatus[MSTATUS_MPIE];
      new_mstatus[MSTATUS_MPIE] = 1'b1;
    end else begin
      new_mstatus[MSTATUS_MPIE] = csr_mstatus[MSTATUS_MIE];
      new_mstatus[MSTATUS_MIE]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
      mstat_q  <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      mstat_q  <= mstat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    tval_d      = tval_q;
    target_d    = target_q;
    mstat_d     = mstat_q;
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    pipe_flush  = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (take_w) begin
          pipe_flush = 1'b1;
          cause_d    = cause_w;
          epc_d      = exe_pc;
          tval_d     = tval_w;
          mstat_d    = new_mstatus;
          target_d   = is_mret_w ? csr_mepc : trap_target;
          state_d    = is_mret_w ? ST_W_MSTAT : ST_W_MEPC;
        end
      end
      ST_W_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = epc_q;
        state_d   = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = ST_W_MTVAL;
      end
      ST_W_MTVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = tval_q;
        state_d   = ST_W_MSTAT;
      end
      ST_W_MSTAT: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstat_q;
        state_d   = ST_REDIR;
      end
      ST_REDIR: begin
        redir_valid = 1'b1;
        redir_pc    = target_q;
        if (redir_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset silences every output even while a stale state is still registered.
    if (rst) begin
      csr_we      = 1'b0;
      csr_waddr   = '0;
      csr_wdata   = '0;
      pipe_flush  = 1'b0;
      redir_valid = 1'b0;
      redir_pc    = '0;
    end
  end

  assign pipe_stall  = (state_q != ST_IDLE) && !rst;
  assign trap_busy   = (state_q != ST_IDLE) && !rst;
  assign dbg_state_o = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: table of single-trap vectors plus hand-written
// sequences for redirect back-pressure and mid-sequence reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid;
  logic [31:0] exe_pc, exe_inst;
  logic        exc_illegal, exc_ecall, exc_ebreak, exc_mret;
  logic        irq_ext, irq_sw, irq_timer;
  logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        pipe_flush, pipe_stall;
  logic        redir_valid, redir_ready;
  logic [31:0] redir_pc;
  logic        trap_busy;
  logic [2:0]  dbg_state;

  trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_inst(exe_inst),
    .exc_illegal(exc_illegal), .exc_ecall(exc_ecall), .exc_ebreak(exc_ebreak), .exc_mret(exc_mret),
    .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .pipe_flush(pipe_flush), .pipe_stall(pipe_stall),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
    .trap_busy(trap_busy), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [43:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc, inst;
    logic [3:0]  exc;      // {illegal, ecall, ebreak, mret}
    logic [2:0]  irq;      // {ext, sw, timer}
    logic [31:0] mstatus, mie, mtvec, mepc;
    logic        take, is_mret;
    logic [31:0] e_mepc, e_mcause, e_mtval, e_mstat, e_redir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic valid, logic [31:0] pc, logic [31:0] inst,
                              logic [3:0] exc, logic [2:0] irq,
                              logic [31:0] mstatus, logic [31:0] mie,
                              logic [31:0] mtvec, logic [31:0] mepc,
                              logic take, logic is_mret,
                              logic [31:0] e_mepc, logic [31:0] e_mcause,
                              logic [31:0] e_mtval, logic [31:0] e_mstat,
                              logic [31:0] e_redir);
    vec_t v;
    v.valid = valid; v.pc = pc; v.inst = inst; v.exc = exc; v.irq = irq;
    v.mstatus = mstatus; v.mie = mie; v.mtvec = mtvec; v.mepc = mepc;
    v.take = take; v.is_mret = is_mret;
    v.e_mepc = e_mepc; v.e_mcause = e_mcause; v.e_mtval = e_mtval;
    v.e_mstat = e_mstat; v.e_redir = e_redir;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    exe_valid = 0; exe_pc = 0; exe_inst = 0;
    exc_illegal = 0; exc_ecall = 0; exc_ebreak = 0; exc_mret = 0;
    irq_ext = 0; irq_sw = 0; irq_timer = 0;
    csr_mstatus = 0; csr_mie = 0; csr_mtvec = 0; csr_mepc = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    exe_valid = v.valid; exe_pc = v.pc; exe_inst = v.inst;
    {exc_illegal, exc_ecall, exc_ebreak, exc_mret} = v.exc;
    {irq_ext, irq_sw, irq_timer} = v.irq;
    csr_mstatus = v.mstatus; csr_mie = v.mie; csr_mtvec = v.mtvec; csr_mepc = v.mepc;
  endtask

  task automatic drive_noise();
    exe_valid = 1; exe_pc = 32'h900; exe_inst = 32'h1234_5678;
    exc_illegal = 1; irq_ext = 1; irq_timer = 1;
    csr_mstatus = 32'h8; csr_mie = 32'h880; csr_mtvec = 32'h1; csr_mepc = 32'h44;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_vector(input int idx, input vec_t v, input int hold, input bit noise);
    bit got_redir;
    bit stall_ok;
    int n_writes;
    int exp_writes;
    apply_vec(v);
    @(negedge clk);
    check($sformatf("v%0d_flush", idx), pipe_flush, v.take);
    if (!v.take) begin
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check($sformatf("v%0d_no_trap_busy", idx), trap_busy, 1'b0);
      @(posedge clk); #1;
      return;
    end
    if (!v.is_mret) begin
      exp_q.push_back({12'h341, v.e_mepc});
      exp_q.push_back({12'h342, v.e_mcause});
      exp_q.push_back({12'h343, v.e_mtval});
    end
    exp_q.push_back({12'h300, v.e_mstat});
    exp_writes = exp_q.size();
    @(posedge clk); #1;
    clear_inputs();
    got_redir = 0; stall_ok = 1; n_writes = 0;
    for (int c = 0; c < 10 && !got_redir; c++) begin
      @(negedge clk);
      if (!pipe_stall || !trap_busy) stall_ok = 0;
      if (csr_we) begin
        n_writes++;
        if (exp_q.size() > 0)
          check($sformatf("v%0d_csr_write%0d", idx, n_writes), {csr_waddr, csr_wdata}, exp_q.pop_front());
      end
      if (redir_valid) got_redir = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    exp_q.delete();
    check($sformatf("v%0d_redir_seen", idx), got_redir, 1'b1);
    check($sformatf("v%0d_stall_busy", idx), stall_ok, 1'b1);
    check($sformatf("v%0d_write_count", idx), n_writes, exp_writes);
    if (!got_redir) begin
      rst = 1; @(posedge clk); #1; rst = 0;
      return;
    end
    check($sformatf("v%0d_redir_pc", idx), redir_pc, v.e_redir);
    if (noise) drive_noise();
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("v%0d_hold%0d", idx, h),
            {pipe_flush, csr_we, redir_valid, pipe_stall, redir_pc}, {4'b0011, v.e_redir});
    end
    redir_ready = 1;
    #1;
    check($sformatf("v%0d_exit_no_accept", idx), {pipe_flush, redir_valid}, 2'b01);
    @(posedge clk); #1;
    redir_ready = 0;
    clear_inputs();
    @(negedge clk);
    check($sformatf("v%0d_back_idle", idx), {trap_busy, pipe_stall, redir_valid, dbg_state}, 6'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- test ----------------
  initial begin
    bit any_we;
    //           valid pc           inst           exc      irq     mstatus       mie       mtvec     mepc     tk mr  e_mepc    e_mcause      e_mtval       e_mstat       e_redir
    vecs.push_back(mk(1, 32'h100, 32'h73,        4'b0100, 3'b000, 32'h8,        32'h0,    32'h200,  32'h0,   1, 0, 32'h100, 32'd11,       32'h0,        32'h1880,     32'h200));
    vecs.push_back(mk(0, 32'h300, 32'h0,         4'b0000, 3'b001, 32'h8,        32'h80,   32'h201,  32'h0,   1, 0, 32'h300, 32'h80000007, 32'h0,        32'h1880,     32'h21C));
    vecs.push_back(mk(1, 32'h400, 32'hDEADBEEF,  4'b1000, 3'b100, 32'h8,        32'h800,  32'h201,  32'h0,   1, 0, 32'h400, 32'h8000000B, 32'h0,        32'h1880,     32'h22C));
    vecs.push_back(mk(1, 32'h110, 32'h30200073,  4'b0001, 3'b000, 32'h1880,     32'h0,    32'h200,  32'h104, 1, 1, 32'h0,   32'h0,        32'h0,        32'h1888,     32'h104));
    vecs.push_back(mk(1, 32'h500, 32'h0000FFFF,  4'b1000, 3'b000, 32'h0,        32'h0,    32'h301,  32'h0,   1, 0, 32'h500, 32'd2,        32'h0000FFFF, 32'h1800,     32'h300));
    vecs.push_back(mk(1, 32'h600, 32'h00100073,  4'b0010, 3'b000, 32'h88,       32'h0,    32'h404,  32'h0,   1, 0, 32'h600, 32'd3,        32'h600,      32'h1880,     32'h404));
    vecs.push_back(mk(1, 32'h700, 32'h73,        4'b0100, 3'b011, 32'h8,        32'h88,   32'h1,    32'h0,   1, 0, 32'h700, 32'h80000003, 32'h0,        32'h1880,     32'hC));
    vecs.push_back(mk(0, 32'h0,   32'h0,         4'b0000, 3'b100, 32'h0,        32'h800,  32'h200,  32'h0,   0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 32'h0,   32'h0,         4'b0000, 3'b001, 32'h8,        32'h800,  32'h200,  32'h0,   0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(0, 32'h100, 32'h73,        4'b0100, 3'b000, 32'h8,        32'h0,    32'h200,  32'h0,   0, 0, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0));
    vecs.push_back(mk(1, 32'h120, 32'h30200073,  4'b0001, 3'b000, 32'h0,        32'h0,    32'h200,  32'h80,  1, 1, 32'h0,   32'h0,        32'h0,        32'h1880,     32'h80));
    vecs.push_back(mk(1, 32'h800, 32'h0,         4'b0111, 3'b000, 32'hFFFFFFFF, 32'h0,    32'h1000, 32'h0,   1, 0, 32'h800, 32'd11,       32'h0,        32'hFFFFFFF7, 32'h1000));

    // reset block, with a live request that must be ignored
    rst = 1; redir_ready = 0;
    clear_inputs();
    exe_valid = 1; exc_ecall = 1; csr_mtvec = 32'h200;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_zero",
          {csr_we, csr_waddr, csr_wdata, pipe_flush, pipe_stall, redir_valid, redir_pc, trap_busy, dbg_state}, '0);
    @(posedge clk); #1;
    clear_inputs();
    rst = 0;
    @(negedge clk);
    check("post_reset_idle",
          {csr_we, csr_waddr, csr_wdata, pipe_flush, pipe_stall, redir_valid, redir_pc, trap_busy, dbg_state}, '0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) run_vector(i, vecs[i], 0, 1'b0);

    // back-pressure on the redirect with competing requests present
    run_vector(100, vecs[0], 5, 1'b1);

    // reset in the middle of a trap sequence
    apply_vec(vecs[0]);
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    check("v6_in_mcause", {dbg_state, csr_we, csr_waddr}, {3'd2, 1'b1, 12'h342});
    rst = 1;
    #1;
    check("v6_outputs_during_rst",
          {csr_we, csr_wdata, pipe_flush, pipe_stall, redir_valid, trap_busy}, '0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("v6_idle_after_rst",
          {csr_we, csr_waddr, csr_wdata, pipe_flush, pipe_stall, redir_valid, redir_pc, trap_busy, dbg_state}, '0);
    any_we = 0;
    repeat (6) begin
      @(negedge clk);
      if (csr_we || redir_valid || trap_busy) any_we = 1;
    end
    check("v6_no_writes_after_rst", any_we, 1'b0);
    @(posedge clk); #1;
    run_vector(200, vecs[4], 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/CSR width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port exe_valid, input, 1: the EXE-stage instruction is valid this cycle.
REQ-005 SHALL have ports exe_pc and exe_inst, inputs, XLEN each: PC and encoding of the EXE instruction.
REQ-006 SHALL have ports exc_illegal, exc_ecall, exc_ebreak, exc_mret, inputs, 1 each: EXE-stage decode flags.
REQ-007 SHALL have ports irq_ext, irq_sw, irq_timer, inputs, 1 each: level interrupt lines.
REQ-008 SHALL have ports csr_mstatus, csr_mie, csr_mtvec, csr_mepc, inputs, XLEN each: current CSR values.
REQ-009 SHALL have ports csr_we (output, 1), csr_waddr (output, 12) and csr_wdata (output, XLEN): single CSR write port.
REQ-010 SHALL have ports pipe_flush and pipe_stall, outputs, 1 each: kill younger instructions and hold the EXE stage.
REQ-011 SHALL have ports redir_valid (out, 1), redir_pc (out, XLEN) and redir_ready (in, 1): fetch redirect handshake.
REQ-012 SHALL have port trap_busy, output, 1: high in every non-IDLE state.

Function
REQ-013 SHALL implement FSM states IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTAT, REDIR.
REQ-014 SHALL evaluate trap requests in IDLE only, and only when exe_valid=1 or an interrupt is enabled.
REQ-015 SHALL take an interrupt when mstatus[3] (MIE)=1 and (irq & mie bit) is set, with bits MEIE=11, MSIE=3, MTIE=7.
REQ-016 SHALL prioritise ext(cause 0x8000000B) > sw(0x80000003) > timer(0x80000007) > illegal(2) > ecall(11) > ebreak(3) > mret.
REQ-017 SHALL, on trap accept, latch cause, epc=exe_pc and tval, then go IDLE->W_MEPC->W_MCAUSE->W_MTVAL->W_MSTAT->REDIR.
REQ-018 SHALL set tval to exe_inst for illegal, exe_pc for ebreak, and 0 otherwise.
REQ-019 SHALL issue exactly one CSR write per W_* state: mepc 0x341=epc; mcause 0x342=cause; mtval 0x343=tval; mstatus 0x300.
REQ-020 SHALL form the trap mstatus write as: MPIE(bit7)=old MIE, MIE(bit3)=0, MPP(bits12:11)=2'b11, all other bits unchanged.
REQ-021 SHALL, on mret accept, go IDLE->W_MSTAT->REDIR with MIE=MPIE, MPIE=1, MPP=2'b11, and redirect target csr_mepc sampled at accept.
REQ-022 SHALL compute the trap target as mtvec&~3, except mtvec[1:0]=01 with an interrupt gives (mtvec&~3)+4*cause[4:0], truncated to XLEN.
REQ-023 SHALL assert pipe_flush for exactly the accept cycle, and pipe_stall in every non-IDLE state.
REQ-024 SHALL hold redir_valid=1 with stable redir_pc in REDIR until redir_ready=1, then return to IDLE on the next cycle.
REQ-025 SHALL ignore new requests and interrupt changes while not IDLE, and SHALL NOT accept a request in the cycle REDIR exits.
REQ-026 SHALL take an interrupt in preference to a simultaneous exception, with epc=exe_pc of the interrupted instruction.
REQ-027 SHALL keep csr_we=0, csr_waddr=0 and csr_wdata=0 outside W_* states.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, enter IDLE and clear latched cause/epc/tval/target, overriding any state including mid-sequence.
REQ-029 SHALL hold all outputs at 0 during and immediately after reset.

Structure
REQ-030 SHALL place the FSM state encoding, the CSR addresses 0x300/0x341/0x342/0x343 and the cause codes in the shared define package.
REQ-031 SHALL use one sub-module, trap_prio_enc, as the combinational priority encoder producing take, is_irq, cause and tval.

Verification
REQ-032 SHALL include test V1: ecall at pc=0x100, mtvec=0x200, mstatus=0x8 -> writes mepc=0x100, mcause=11, mtval=0, mstatus=0x1880; redir_pc=0x200.
REQ-033 SHALL include test V2: irq_timer with mie=0x80, MIE=1, mtvec=0x201 -> mcause=0x80000007 and redir_pc=0x21C.
REQ-034 SHALL include test V3: illegal and irq_ext in the same cycle -> cause 0x8000000B with a single trap sequence.
REQ-035 SHALL include test V4: mret with mstatus=0x1880 and mepc=0x104 -> one write mstatus=0x1888, redir_pc=0x104, no mepc/mcause writes.
REQ-036 SHALL include test V5: redir_ready held low for 5 cycles -> redir_valid and redir_pc stable, pipe_stall high throughout.
REQ-037 SHALL include test V6: rst asserted in W_MCAUSE -> next cycle IDLE, all outputs 0, and no further CSR writes.
